instruction_fetch_responder: RTL and testbench

Memory-side responder for the core's instruction-fetch interface. It accepts word-aligned fetch requests through a valid/ready handshake and reads them from a synchronous-read instruction RAM. Responses are returned in order through a 2-entry response FIFO, so the fetch stage can apply backpressure. A load port lets the boot/debug loader write program words, and a flush input lets the core discard pending fetches on a redirect.

---
 rtl/instruction_fetch_responder.sv | 146 ++++++++++++++
 tb/tb_instruction_fetch_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_responder.sv
// Instruction-fetch responder: valid/ready fetch requests, synchronous-read instruction RAM,
// and a 2-entry in-order response FIFO with flush and a program-load write port.
module instruction_fetch_responder #(
    parameter int XLEN         = 32,
    parameter int MEMORY_DEPTH = 1024,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Req_Valid,
    output logic                  o_Req_Ready,
    input  logic [XLEN-1:0]       i_Req_Addr,
    output logic                  o_Rsp_Valid,
    input  logic                  i_Rsp_Ready,
    output logic [XLEN-1:0]       o_Rsp_Instruction,
    output logic                  o_Rsp_Fault,
    input  logic                  i_Flush,
    input  logic                  i_Load_Enable,
    input  logic [ADDR_WIDTH-1:0] i_Load_Addr,
    input  logic [XLEN-1:0]       i_Load_Data
);

    localparam logic [XLEN-1:0] NOP_INSN = XLEN'(32'h0000_0013);

    logic [XLEN-1:0]       mem [MEMORY_DEPTH];
    logic [XLEN-1:0]       rd_data_reg;
    logic                  inflight_reg;
    logic                  inflight_fault_reg;
    logic [1:0]            count_reg;
    logic [1:0]            count_next;
    logic                  wr_ptr_reg;
    logic                  wr_ptr_next;
    logic                  rd_ptr_reg;
    logic                  rd_ptr_next;
    logic [XLEN-1:0]       entry_instr [2];
    logic                  entry_fault [2];

    logic                  req_fault;
    logic [ADDR_WIDTH-1:0] req_index;
    logic [2:0]            occupancy;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic [XLEN-1:0]       push_instr;

    assign req_index = i_Req_Addr[ADDR_WIDTH+1:2];
    assign req_fault = (i_Req_Addr[1:0] != 2'b00) ||
                       (i_Req_Addr[XLEN-1:2] >= (XLEN-2)'(MEMORY_DEPTH));

    assign o_Rsp_Valid = (count_reg != 2'd0);
    assign pop         = o_Rsp_Valid && i_Rsp_Ready;
    assign occupancy   = {1'b0, count_reg} + {2'b00, inflight_reg};

    // A pop this cycle frees a slot, so i_Rsp_Ready reaches o_Req_Ready combinationally.
    assign o_Req_Ready = !i_Reset && !i_Load_Enable && !i_Flush &&
                         (occupancy < (3'd2 + {2'b00, pop}));
    assign accept      = i_Req_Valid && o_Req_Ready;
    assign push        = inflight_reg && !i_Flush;
    assign push_instr  = inflight_fault_reg ? NOP_INSN : rd_data_reg;

    // Block RAM: no reset; a fetch and a load never collide because loads block requests.
    always_ff @(posedge i_Clock) begin
        if (i_Load_Enable) begin
            mem[i_Load_Addr] <= i_Load_Data;
        end
        if (accept && !req_fault) begin
            rd_data_reg <= mem[req_index];
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            inflight_reg       <= 1'b0;
            inflight_fault_reg <= 1'b0;
        end else if (i_Flush) begin
            inflight_reg       <= 1'b0;
            inflight_fault_reg <= 1'b0;
        end else begin
            inflight_reg <= accept;
            if (accept) begin
                inflight_fault_reg <= req_fault;
            end
        end
    end

    always_comb begin
        count_next  = count_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (i_Flush) begin
            count_next  = 2'd0;
            wr_ptr_next = 1'b0;
            rd_ptr_next = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_next = ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_next = ~rd_ptr_reg;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + 2'd1;
                2'b01:   count_next = count_reg - 2'd1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            count_reg  <= count_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_entry
            logic [XLEN-1:0] instr_reg;
            logic            fault_reg;

            always_ff @(posedge i_Clock or posedge i_Reset) begin
                if (i_Reset) begin
                    instr_reg <= '0;
                    fault_reg <= 1'b0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    instr_reg <= push_instr;
                    fault_reg <= inflight_fault_reg;
                end
            end

            assign entry_instr[gi] = instr_reg;
            assign entry_fault[gi] = fault_reg;
        end
    endgenerate

    // Head entry only changes on push into an empty FIFO or on pop, so it holds under backpressure.
    assign o_Rsp_Instruction = entry_instr[rd_ptr_reg];
    assign o_Rsp_Fault       = entry_fault[rd_ptr_reg];

endmodule

// File: tb/tb_instruction_fetch_responder.sv
// Directed bench for instruction_fetch_responder: streaming, backpressure, faults, flush,
// program load and asynchronous reset, with hand-computed expected responses.
module tb_instruction_fetch_responder;

    logic        i_Clock;
    logic        i_Reset;
    logic        i_Req_Valid;
    logic        o_Req_Ready;
    logic [31:0] i_Req_Addr;
    logic        o_Rsp_Valid;
    logic        i_Rsp_Ready;
    logic [31:0] o_Rsp_Instruction;
    logic        o_Rsp_Fault;
    logic        i_Flush;
    logic        i_Load_Enable;
    logic [9:0]  i_Load_Addr;
    logic [31:0] i_Load_Data;

    int tests_run   = 0;
    int tests_fail  = 0;
    int occ_errors  = 0;

    logic [31:0] s_addr  [4];
    logic [31:0] s_instr [4];
    logic        s_fault [4];
    logic        s_chk   [4];

    localparam logic [31:0] W0  = 32'h0010_0093;
    localparam logic [31:0] W1  = 32'h0020_0113;
    localparam logic [31:0] W2  = 32'h0030_0193;
    localparam logic [31:0] W3  = 32'h0040_0213;
    localparam logic [31:0] NOP = 32'h0000_0013;

    instruction_fetch_responder #(
        .XLEN(32), .MEMORY_DEPTH(1024), .ADDR_WIDTH(10)
    ) dut (
        .i_Clock(i_Clock), .i_Reset(i_Reset),
        .i_Req_Valid(i_Req_Valid), .o_Req_Ready(o_Req_Ready), .i_Req_Addr(i_Req_Addr),
        .o_Rsp_Valid(o_Rsp_Valid), .i_Rsp_Ready(i_Rsp_Ready),
        .o_Rsp_Instruction(o_Rsp_Instruction), .o_Rsp_Fault(o_Rsp_Fault),
        .i_Flush(i_Flush), .i_Load_Enable(i_Load_Enable),
        .i_Load_Addr(i_Load_Addr), .i_Load_Data(i_Load_Data)
    );

    initial begin
        i_Clock = 1'b0;
        forever #5 i_Clock = ~i_Clock;
    end

    // Occupancy must never exceed the two FIFO slots (also catches counter wrap).
    always @(negedge i_Clock) begin
        if (!i_Reset && ((int'(dut.count_reg) + int'(dut.inflight_reg)) > 2)) begin
            occ_errors++;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_Clock);
        #1;
    endtask

    // Back-to-back stream of n requests with rsp_ready held high; responses expected
    // two cursor steps after each request is presented.
    task automatic stream(input int n);
        i_Rsp_Ready = 1'b1;
        for (int k = 0; k < n + 2; k++) begin
            if (k < n) begin
                i_Req_Valid = 1'b1;
                i_Req_Addr  = s_addr[k];
            end else begin
                i_Req_Valid = 1'b0;
            end
            #1;
            if (k < n) check_value("stream_req_ready", {31'b0, o_Req_Ready}, 32'd1);
            if (k < 2) begin
                check_value("stream_rsp_idle", {31'b0, o_Rsp_Valid}, 32'd0);
            end else begin
                check_value("stream_rsp_valid", {31'b0, o_Rsp_Valid}, 32'd1);
                if (s_chk[k-2]) check_value("stream_rsp_instr", o_Rsp_Instruction, s_instr[k-2]);
                check_value("stream_rsp_fault", {31'b0, o_Rsp_Fault}, {31'b0, s_fault[k-2]});
                $display("[TB] rsp addr=0x%08h instr=0x%08h fault=%0d",
                         s_addr[k-2], o_Rsp_Instruction, o_Rsp_Fault);
            end
            tick();
        end
        #1;
        check_value("stream_drained", {31'b0, o_Rsp_Valid}, 32'd0);
    endtask

    task automatic load_word(input logic [9:0] addr, input logic [31:0] data);
        i_Load_Enable = 1'b1;
        i_Load_Addr   = addr;
        i_Load_Data   = data;
        tick();
        i_Load_Enable = 1'b0;
        $display("[TB] load word %0d = 0x%08h", addr, data);
    endtask

    initial begin
        i_Reset = 1'b1; i_Req_Valid = 1'b1; i_Req_Addr = '0; i_Rsp_Ready = 1'b1;
        i_Flush = 1'b0; i_Load_Enable = 1'b0; i_Load_Addr = '0; i_Load_Data = '0;
        tick(); tick();
        check_value("reset_rsp_valid", {31'b0, o_Rsp_Valid}, 32'd0);
        check_value("reset_req_ready", {31'b0, o_Req_Ready}, 32'd0);
        check_value("reset_instr", o_Rsp_Instruction, 32'd0);
        check_value("reset_fault", {31'b0, o_Rsp_Fault}, 32'd0);
        i_Reset = 1'b0; i_Req_Valid = 1'b0;
        tick();

        load_word(10'd0, W0); load_word(10'd1, W1);
        load_word(10'd2, W2); load_word(10'd3, W3);

        // Back-to-back throughput
        s_addr  = '{32'd0, 32'd4, 32'd8, 32'd12};
        s_instr = '{W0, W1, W2, W3};
        s_fault = '{1'b0, 1'b0, 1'b0, 1'b0};
        s_chk   = '{1'b1, 1'b1, 1'b1, 1'b1};
        stream(4);

        // Backpressure: third request stalls until the consumer pops
        i_Rsp_Ready = 1'b0;
        i_Req_Valid = 1'b1; i_Req_Addr = 32'd0; #1;
        check_value("bp_ready_0", {31'b0, o_Req_Ready}, 32'd1);
        tick();
        i_Req_Addr = 32'd4; #1;
        check_value("bp_ready_1", {31'b0, o_Req_Ready}, 32'd1);
        tick();
        i_Req_Addr = 32'd8; #1;
        check_value("bp_ready_2_blocked", {31'b0, o_Req_Ready}, 32'd0);
        tick();
        check_value("bp_still_blocked", {31'b0, o_Req_Ready}, 32'd0);
        check_value("bp_head_hold", o_Rsp_Instruction, W0);
        i_Rsp_Ready = 1'b1; #1;
        check_value("bp_ready_on_pop", {31'b0, o_Req_Ready}, 32'd1);
        tick();
        i_Req_Valid = 1'b0;
        check_value("bp_second_rsp", o_Rsp_Instruction, W1);
        tick();
        check_value("bp_third_valid", {31'b0, o_Rsp_Valid}, 32'd1);
        check_value("bp_third_rsp", o_Rsp_Instruction, W2);
        tick();
        check_value("bp_drained", {31'b0, o_Rsp_Valid}, 32'd0);
        $display("[TB] backpressure sequence done");

        // Faults: misaligned, just out of range, last valid word
        s_addr  = '{32'h2, 32'h1000, 32'hFFC, 32'h0};
        s_instr = '{NOP, NOP, 32'h0, 32'h0};
        s_fault = '{1'b1, 1'b1, 1'b0, 1'b0};
        s_chk   = '{1'b1, 1'b1, 1'b0, 1'b0};
        stream(3);

        // Flush with one entry buffered and one in flight
        i_Rsp_Ready = 1'b0;
        i_Req_Valid = 1'b1; i_Req_Addr = 32'd0;
        tick();
        i_Req_Addr = 32'd4;
        tick();
        i_Req_Valid = 1'b0;
        check_value("flush_pre_valid", {31'b0, o_Rsp_Valid}, 32'd1);
        i_Flush = 1'b1; i_Req_Valid = 1'b1; i_Req_Addr = 32'd12; #1;
        check_value("flush_req_blocked", {31'b0, o_Req_Ready}, 32'd0);
        tick();
        i_Flush = 1'b0; i_Req_Valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_value("flush_no_stale", {31'b0, o_Rsp_Valid}, 32'd0);
            tick();
        end
        $display("[TB] flush done");
        s_addr  = '{32'd8, 32'd0, 32'd0, 32'd0};
        s_instr = '{W2, 32'd0, 32'd0, 32'd0};
        s_fault = '{1'b0, 1'b0, 1'b0, 1'b0};
        s_chk   = '{1'b1, 1'b0, 1'b0, 1'b0};
        stream(1);

        // Load blocks requests
        i_Rsp_Ready = 1'b1;
        i_Req_Valid = 1'b1; i_Req_Addr = 32'd4;
        i_Load_Enable = 1'b1; i_Load_Addr = 10'd1; i_Load_Data = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_value("load_req_blocked", {31'b0, o_Req_Ready}, 32'd0);
            tick();
        end
        i_Load_Enable = 1'b0; i_Req_Valid = 1'b0;
        $display("[TB] load word 1 = 0xdeadbeef");
        s_addr  = '{32'd4, 32'd0, 32'd0, 32'd0};
        s_instr = '{32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0};
        stream(1);

        // Read accepted the cycle before a load to the same word returns old data
        i_Req_Valid = 1'b1; i_Req_Addr = 32'd8;
        tick();
        i_Req_Valid = 1'b0;
        i_Load_Enable = 1'b1; i_Load_Addr = 10'd2; i_Load_Data = 32'hCAFE_F00D;
        tick();
        i_Load_Enable = 1'b0;
        check_value("read_first_old", o_Rsp_Instruction, W2);
        tick();
        s_addr  = '{32'd8, 32'd0, 32'd0, 32'd0};
        s_instr = '{32'hCAFE_F00D, 32'd0, 32'd0, 32'd0};
        stream(1);

        // Asynchronous reset with one entry buffered
        i_Rsp_Ready = 1'b0;
        i_Req_Valid = 1'b1; i_Req_Addr = 32'd0;
        tick();
        i_Req_Valid = 1'b0;
        tick();
        check_value("areset_pre_valid", {31'b0, o_Rsp_Valid}, 32'd1);
        #2 i_Reset = 1'b1;
        #1;
        check_value("areset_rsp_valid", {31'b0, o_Rsp_Valid}, 32'd0);
        check_value("areset_req_ready", {31'b0, o_Req_Ready}, 32'd0);
        check_value("areset_instr", o_Rsp_Instruction, 32'd0);
        tick();
        i_Reset = 1'b0; #1;
        check_value("post_reset_ready", {31'b0, o_Req_Ready}, 32'd1);
        check_value("post_reset_valid", {31'b0, o_Rsp_Valid}, 32'd0);
        tick();
        s_addr  = '{32'd0, 32'd0, 32'd0, 32'd0};
        s_instr = '{W0, 32'd0, 32'd0, 32'd0};
        stream(1);

        check_value("occupancy_bound", occ_errors, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
